// File: rtl/alu16_seq_pkg.sv
// alu16_seq_pkg -- shared constants for the 16-bit sequencer and its 8-bit ALU.
//   alu_op_t      : op codes understood by the external 8-bit ALU
//   alu16_op_t    : 16-bit operations run by alu16_seq (ADD16, INC16, DEC16, ADDSP)
//   alu16_state_t : alu16_seq FSM states
//   nib_carry()   : carry out of a 4-bit add, used for half-carry flags
package alu16_seq_pkg;

  typedef enum logic [3:0] {
    alu_NOP = 4'd0,
    alu_ADD = 4'd1,
    alu_ADC = 4'd2,
    alu_SUB = 4'd3,
    alu_SBC = 4'd4,
    alu_AND = 4'd5,
    alu_XOR = 4'd6,
    alu_OR  = 4'd7,
    alu_CP  = 4'd8
  } alu_op_t;

  typedef enum logic [1:0] {
    ADD16 = 2'd0,
    INC16 = 2'd1,
    DEC16 = 2'd2,
    ADDSP = 2'd3
  } alu16_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } alu16_state_t;

  // Carry out of x + y + cin over one nibble.
  function automatic logic nib_carry(input logic [3:0] x, input logic [3:0] y, input logic cin);
    logic [4:0] sum;
    sum = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    return sum[4];
  endfunction

endpackage

// File: rtl/alu16_seq.sv
// alu16_seq -- runs a 16-bit operation as two byte passes through an external
// 8-bit ALU (low byte, then high byte with carry), then pulses done.
// Ports:
//   clk, rst_b            clock, asynchronous active-low reset
//   start, op             request pulse (sampled in IDLE only) and operation
//   opnd_a, opnd_b        operands; ADDSP uses opnd_b[7:0] as signed e8
//   flags_in              current {Z,N,H,C}
//   busy, done, err       status; err is valid with done
//   result, flags_out     16-bit result and {Z,N,H,C}, held until next accepted start
//   alu_op/a/b/cf         drive to the 8-bit ALU
//   alu_res, alu_nf       ALU result and next flags
// Configuration: define ALU16_ADDSP_EN to support ADDSP; otherwise ADDSP
// completes in one cycle with err=1 and the operand/flags passed through.
module alu16_seq
  import alu16_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_b,
  input  logic        start,
  input  alu16_op_t   op,
  input  logic [15:0] opnd_a,
  input  logic [15:0] opnd_b,
  input  logic [3:0]  flags_in,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] result,
  output logic [3:0]  flags_out,
  output alu_op_t     alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_cf,
  input  logic [7:0]  alu_res,
  input  logic [3:0]  alu_nf
);

`ifdef ALU16_ADDSP_EN
  localparam logic ADDSP_EN = 1'b1;
`else
  localparam logic ADDSP_EN = 1'b0;
`endif

  alu16_state_t state_q, state_d;
  alu16_op_t    op_q;
  logic [15:0]  a_q, b_q;
  logic [3:0]   flags_q;
  logic         cy_q;
  logic [7:0]   lo_q;
  logic [15:0]  result_q;
  logic [3:0]   flags_out_q;
  logic         busy_q, done_q, err_q;

  logic         accept_s, unsup_s;
  logic [8:0]   hi_sum_s;
  logic [3:0]   flags_hi_s;
  logic         unused_nf_s;

  assign accept_s = (state_q == IDLE) && start;
  assign unsup_s  = (op == ADDSP) && !ADDSP_EN;
  // Only the carry bit of the ALU flags is consumed; H is rebuilt locally.
  assign unused_nf_s = ^alu_nf[3:1];

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = unsup_s ? DONE : LO;
        end else begin
          state_d = IDLE;
        end
      end
      LO:      state_d = HI;
      HI:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ALU drive: low byte in LO, high byte with carry-in in HI, idle otherwise.
  always_comb begin
    alu_op = alu_NOP;
    alu_a  = 8'h00;
    alu_b  = 8'h00;
    alu_cf = 4'h0;
    case (state_q)
      LO: begin
        alu_a = a_q[7:0];
        case (op_q)
          ADD16:   begin alu_op = alu_ADD; alu_b = b_q[7:0]; end
          INC16:   begin alu_op = alu_ADD; alu_b = 8'h01;    end
          DEC16:   begin alu_op = alu_SUB; alu_b = 8'h01;    end
          ADDSP:   begin alu_op = alu_ADD; alu_b = b_q[7:0]; end
          default: begin alu_op = alu_NOP; alu_b = 8'h00;    end
        endcase
      end
      HI: begin
        alu_a  = a_q[15:8];
        alu_cf = {3'b000, cy_q};
        case (op_q)
          ADD16:   begin alu_op = alu_ADC; alu_b = b_q[15:8];     end
          INC16:   begin alu_op = alu_ADC; alu_b = 8'h00;         end
          DEC16:   begin alu_op = alu_SBC; alu_b = 8'h00;         end
          ADDSP:   begin alu_op = alu_ADC; alu_b = {8{b_q[7]}};   end
          default: begin alu_op = alu_NOP; alu_b = 8'h00;         end
        endcase
      end
      default: begin
        alu_op = alu_NOP;
        alu_a  = 8'h00;
        alu_b  = 8'h00;
        alu_cf = 4'h0;
      end
    endcase
  end

  // Flags captured at the end of HI, built from the latched operands and cy.
  always_comb begin
    hi_sum_s = {1'b0, a_q[15:8]} + {1'b0, b_q[15:8]} + {8'h00, cy_q};
    case (op_q)
      ADD16:   flags_hi_s = {flags_q[3], 1'b0, nib_carry(a_q[11:8], b_q[11:8], cy_q), hi_sum_s[8]};
      ADDSP:   flags_hi_s = {2'b00, nib_carry(a_q[3:0], b_q[3:0], 1'b0), cy_q};
      default: flags_hi_s = flags_q;
    endcase
  end

  // State and registered status outputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      err_q   <= accept_s && unsup_s;
    end
  end

  // Operand capture and byte-wise result assembly.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      op_q        <= ADD16;
      a_q         <= 16'h0000;
      b_q         <= 16'h0000;
      flags_q     <= 4'h0;
      cy_q        <= 1'b0;
      lo_q        <= 8'h00;
      result_q    <= 16'h0000;
      flags_out_q <= 4'h0;
    end else begin
      if (accept_s) begin
        op_q    <= op;
        a_q     <= opnd_a;
        b_q     <= opnd_b;
        flags_q <= flags_in;
        if (unsup_s) begin
          result_q    <= opnd_a;
          flags_out_q <= flags_in;
        end
      end
      if (state_q == LO) begin
        lo_q <= alu_res;
        cy_q <= alu_nf[0];
      end
      // Result is published whole so it never shows a half-updated value.
      if (state_q == HI) begin
        result_q    <= {alu_res, lo_q};
        flags_out_q <= flags_hi_s;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign result    = result_q;
  assign flags_out = flags_out_q;

endmodule

// File: doc/alu16_seq.md
ALU16_SEQ -- requirements
Module: alu16_seq

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst_b  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 op  input  alu16_op_t (2)  ADD16, INC16, DEC16, ADDSP.
REQ-006 opnd_a  input  16  first operand (HL / rr / SP).
REQ-007 opnd_b  input  16  second operand; ADDSP uses opnd_b[7:0] as signed e8.
REQ-008 flags_in  input  4  current {Z,N,H,C}.
REQ-009 busy  output  1  high whenever state != IDLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 err  output  1  valid with done; op not supported.
REQ-012 result  output  16  16-bit result; held until next accepted start.
REQ-013 flags_out  output  4  resulting {Z,N,H,C}; held like result.
REQ-014 alu_op  output  alu_op_t  op code to 8-bit ALU.
REQ-015 alu_a, alu_b  output  8 each  ALU operands.
REQ-016 alu_cf  output  4  curr_flags presented to ALU.
REQ-017 alu_res, alu_nf  input  8, 4  ALU result and next_flags.

Function
REQ-018 FSM states IDLE, LO, HI, DONE; IDLE->LO on start; LO->HI; HI->DONE; DONE->IDLE unconditionally.
REQ-019 On accepted start: latch op, opnd_a, opnd_b, flags_in; inputs may change afterwards.
REQ-020 start while busy SHALL be ignored, not queued.
REQ-021 Latency: start at cycle 0 -> done=1 in cycle 3; busy high cycles 1-3; back-to-back start accepted in cycle 4.
REQ-022 LO cycle: alu_a=a[7:0]; ADD16 alu_ADD,b[7:0]; INC16 alu_ADD,0x01; DEC16 alu_SUB,0x01; ADDSP alu_ADD,e8.
REQ-023 LO cycle: register alu_res as result[7:0] and alu_nf[0] as byte carry/borrow cy; alu_cf[0]=0.
REQ-024 HI cycle: alu_a=a[15:8]; alu_cf[0]=cy; ADD16 alu_ADC,b[15:8]; INC16 alu_ADC,0x00; DEC16 alu_SBC,0x00; ADDSP alu_ADC,{8{e8[7]}}.
REQ-025 HI cycle: register alu_res as result[15:8].
REQ-026 IDLE/DONE: alu_op=alu_NOP, alu_a=alu_b=0, alu_cf=0.
REQ-027 ADD16 flags: Z=latched Z, N=0, H=carry out of bit 11 (a[11:8]+b[11:8]+cy), C=carry out of bit 15.
REQ-028 INC16/DEC16 flags: flags_out=latched flags_in, unchanged.
REQ-029 ADDSP flags: Z=0, N=0, H=carry out of bit 3, C=carry out of bit 7 (unsigned low-byte add).
REQ-030 H SHALL be computed in-block from latched operands and cy, not taken from alu_nf[1].
REQ-031 Wrap-around modulo 2^16: 0xFFFF+1=0x0000, 0x0000-1=0xFFFF, no error.

Reset
REQ-032 rst_b low: state=IDLE, busy=0, done=0, err=0, result=0x0000, flags_out=0x0, ALU drive per REQ-026.
REQ-033 Reset mid-operation SHALL abort with no done pulse; next start after release behaves normally.

Configuration
REQ-034 Macro ALU16_ADDSP_EN defined: ADDSP supported per REQ-022/024/029.
REQ-035 Macro ALU16_ADDSP_EN undefined: ADDSP start goes IDLE->DONE in one cycle, done=1, err=1, result=opnd_a, flags_out=flags_in, ALU stays alu_NOP.

Structure
REQ-036 alu16_op_t and state enum SHALL live in the shared constants package alongside alu_op_t.
REQ-037 No sub-module; the 8-bit alu is instantiated by the parent, not inside this block.

Verification
REQ-038 ADD16 a=0x8A23 b=0x0605 flags_in=0x8 -> done cycle 3, result=0x9028, flags_out=0xA (Z1 N0 H1 C0).
REQ-039 INC16 a=0x00FF flags_in=0x5 -> result=0x0100, flags_out=0x5; DEC16 a=0x0000 -> result=0xFFFF, flags unchanged.
REQ-040 ADDSP a=0xFFF8 b[7:0]=0x08 -> result=0x0000, flags_out=0x3; ADDSP a=0x0005 e8=0xFE -> result=0x0003, flags_out=0x3.
REQ-041 start held high cycles 0-5 with ADD16 -> exactly two done pulses, cycles 3 and 7.
REQ-042 rst_b asserted in HI cycle -> busy=0, done never pulses, result=0x0000; following INC16 0x1234 -> 0x1235.
REQ-043 ALU16_ADDSP_EN undefined, ADDSP a=0x1234 -> done and err in cycle 1, result=0x1234, alu_op=alu_NOP throughout.
